// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the barrel-shifter command stage and rotate stage chain.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: op encodings and the rotate-stage count derivation, so the command
// stage and the stage chain always agree on OSHIFT width.
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        OP_ROR  = 2'b00,
        OP_ROL  = 2'b01,
        OP_PASS = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Number of rotate stages (and OSHIFT bits) for a given data width.
    function automatic int unsigned shamt_width(input int unsigned data_width);
        return (data_width < 2) ? 1 : $clog2(data_width);
    endfunction

endpackage

// File: rtl/barrel_shift_cmd_fifo.sv
// Generic 2-entry synchronous FIFO with occupancy counter and head/tail pointers.
// Latency: 1 cycle push-to-pop, no bypass; one beat per cycle when pop_rdy stays high.
// Backpressure: push_rdy = rst_n & ~full from registered state only; no pop_rdy -> push_rdy path.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   push_vld/rdy/dat     write side
//   pop_vld/rdy/dat      read side; pop_dat shows the head entry, zero when empty
module barrel_shift_cmd_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    logic push_fire;
    logic pop_fire;

    assign push_rdy  = rst_n & (count_q != 2'd2);
    assign pop_vld   = (count_q != 2'd0);
    assign push_fire = push_vld & push_rdy;
    assign pop_fire  = pop_vld & pop_rdy;

    // Stale entries stay in storage after a pop; gating keeps the output at zero when empty.
    assign pop_dat = pop_vld ? mem_q[head_q] : '0;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (push_fire) begin
            mem_d[tail_q] = push_dat;
            tail_d        = ~tail_q;
        end
        if (pop_fire) begin
            head_d = ~head_q;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/barrel_shift_cmd_stage.sv
// Command/operand stage: decodes {op, amount} to rotate-right stage enables and buffers 2 beats.
// Latency: 1 cycle from acceptance to OVALID, no bypass; full throughput while OREADY is high.
// Backpressure: IREADY drops only when both entries are held; it rises the cycle after a pop.
//
// Ports:
//   CLK, RST_N             clock, synchronous active-low reset
//   IVALID/IREADY          input handshake; IDATA operand, IOP op (ROR/ROL/PASS/rsvd), IAMT raw amount
//   OVALID/OREADY          output handshake; ODATA operand, OSHIFT per-stage enables
//                          (bit k = rotate right by 2^k), OERR amount-range error
//
// Build option BARREL_SHIFT_AMT_CHECK_EN: ROR/ROL with IAMT >= DATA_WIDTH is still
// accepted but stored unrotated (OSHIFT=0) with OERR=1. Without it the amount is
// reduced modulo DATA_WIDTH and OERR is always 0. Port list is the same in both builds.
module barrel_shift_cmd_stage
    import barrel_shift_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned AMT_WIDTH   = 8,
    localparam int unsigned SHAMT_WIDTH = shamt_width(DATA_WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   IVALID,
    output logic                   IREADY,
    input  logic [DATA_WIDTH-1:0]  IDATA,
    input  logic [1:0]             IOP,
    input  logic [AMT_WIDTH-1:0]   IAMT,
    output logic                   OVALID,
    input  logic                   OREADY,
    output logic [DATA_WIDTH-1:0]  ODATA,
    output logic [SHAMT_WIDTH-1:0] OSHIFT,
    output logic                   OERR
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [SHAMT_WIDTH-1:0] shift;
        logic                   err;
    } cmd_t;

    localparam int unsigned CMD_WIDTH = $bits(cmd_t);

    cmd_t                   dec_cmd;
    cmd_t                   head_cmd;
    logic [SHAMT_WIDTH-1:0] amt_lo;

    // Amount modulo DATA_WIDTH is just the low bits since DATA_WIDTH is a power of two.
    assign amt_lo = IAMT[SHAMT_WIDTH-1:0];

`ifdef BARREL_SHIFT_AMT_CHECK_EN
    logic amt_over;
    // Any bit above the stage range set means IAMT >= DATA_WIDTH; this form stays
    // correct even when AMT_WIDTH equals SHAMT_WIDTH.
    assign amt_over = |(IAMT >> SHAMT_WIDTH);
`else
    logic unused_amt_hi;
    assign unused_amt_hi = |(IAMT >> SHAMT_WIDTH);
`endif

    always_comb begin
        dec_cmd.data  = IDATA;
        dec_cmd.shift = '0;
        dec_cmd.err   = 1'b0;

        case (op_e'(IOP))
            OP_ROR:  dec_cmd.shift = amt_lo;
            // Rotate left by A == rotate right by (N - A) mod N; wraps so ROL 0 gives 0.
            OP_ROL:  dec_cmd.shift = SHAMT_WIDTH'(0) - amt_lo;
            default: dec_cmd.shift = '0;
        endcase

`ifdef BARREL_SHIFT_AMT_CHECK_EN
        if ((op_e'(IOP) == OP_ROR || op_e'(IOP) == OP_ROL) && amt_over) begin
            dec_cmd.shift = '0;
            dec_cmd.err   = 1'b1;
        end
`endif
    end

    barrel_shift_cmd_fifo #(
        .WIDTH (CMD_WIDTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push_vld (IVALID),
        .push_rdy (IREADY),
        .push_dat (dec_cmd),
        .pop_vld  (OVALID),
        .pop_rdy  (OREADY),
        .pop_dat  (head_cmd)
    );

    assign ODATA  = head_cmd.data;
    assign OSHIFT = head_cmd.shift;
    assign OERR   = head_cmd.err;

endmodule

// File: tb/tb_barrel_shift_cmd_stage.sv
// Directed self-checking bench for barrel_shift_cmd_stage (default parameters).
// Latency: n/a.
// Backpressure: exercised via OREADY low with three back-to-back commands.
module tb_barrel_shift_cmd_stage;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = 5;

    logic          clk;
    logic          rst_n;
    logic          ivalid;
    logic          iready;
    logic [DW-1:0] idata;
    logic [1:0]    iop;
    logic [AW-1:0] iamt;
    logic          ovalid;
    logic          oready;
    logic [DW-1:0] odata;
    logic [SW-1:0] oshift;
    logic          oerr;

    int checks   = 0;
    int failures = 0;

    barrel_shift_cmd_stage #(
        .DATA_WIDTH (DW),
        .AMT_WIDTH  (AW)
    ) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .IVALID (ivalid),
        .IREADY (iready),
        .IDATA  (idata),
        .IOP    (iop),
        .IAMT   (iamt),
        .OVALID (ovalid),
        .OREADY (oready),
        .ODATA  (odata),
        .OSHIFT (oshift),
        .OERR   (oerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it, away from the sampling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] amt, input logic [31:0] data);
        ivalid = 1'b1;
        iop    = op;
        iamt   = amt;
        idata  = data;
    endtask

    // Single command with OREADY high: visible one cycle after acceptance, gone the next.
    task automatic send_one(input string tag, input logic [1:0] op, input logic [7:0] amt,
                            input logic [31:0] data, input logic [4:0] exp_shift,
                            input logic exp_err);
        oready = 1'b1;
        drive(op, amt, data);
        step();
        ivalid = 1'b0;
        check({tag, "_ovalid"}, 32'(ovalid), 32'd1);
        check({tag, "_odata"},  odata,       data);
        check({tag, "_oshift"}, 32'(oshift), 32'(exp_shift));
        check({tag, "_oerr"},   32'(oerr),   32'(exp_err));
        step();
        check({tag, "_drain"},  32'(ovalid), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        ivalid = 1'b0;
        oready = 1'b0;
        idata  = '0;
        iop    = 2'b00;
        iamt   = '0;

        // Reset and idle
        step();
        step();
        check("rst_iready_low", 32'(iready), 32'd0);
        check("rst_ovalid",     32'(ovalid), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_iready", 32'(iready), 32'd1);
        check("idle_ovalid", 32'(ovalid), 32'd0);
        check("idle_odata",  odata,       32'd0);
        check("idle_oshift", 32'(oshift), 32'd0);
        check("idle_oerr",   32'(oerr),   32'd0);

        // Decode cases
        send_one("ror5",  2'b00, 8'd5, 32'h8000_0001, 5'b00101, 1'b0);
        send_one("rol1",  2'b01, 8'd1, 32'hDEAD_BEEF, 5'b11111, 1'b0);
        send_one("rol0",  2'b01, 8'd0, 32'h1234_5678, 5'b00000, 1'b0);
        send_one("pass7", 2'b10, 8'd7, 32'hCAFE_F00D, 5'b00000, 1'b0);
        send_one("rsvd3", 2'b11, 8'd3, 32'h0F0F_0F0F, 5'b00000, 1'b0);
        send_one("ror31", 2'b00, 8'd31, 32'hA5A5_5A5A, 5'b11111, 1'b0);
`ifdef BARREL_SHIFT_AMT_CHECK_EN
        send_one("ror40", 2'b00, 8'd40, 32'h0000_00FF, 5'b00000, 1'b1);
        send_one("rol40", 2'b01, 8'd40, 32'h0000_FF00, 5'b00000, 1'b1);
        send_one("rol32", 2'b01, 8'd32, 32'h00FF_0000, 5'b00000, 1'b1);
        send_one("pass40", 2'b10, 8'd40, 32'hFF00_0000, 5'b00000, 1'b0);
`else
        send_one("ror40", 2'b00, 8'd40, 32'h0000_00FF, 5'b01000, 1'b0);
        send_one("rol40", 2'b01, 8'd40, 32'h0000_FF00, 5'b11000, 1'b0);
        send_one("rol32", 2'b01, 8'd32, 32'h00FF_0000, 5'b00000, 1'b0);
        send_one("pass40", 2'b10, 8'd40, 32'hFF00_0000, 5'b00000, 1'b0);
`endif

        // Backpressure: A, B accepted, C held while full
        oready = 1'b0;
        drive(2'b00, 8'd1, 32'h1111_1111);
        step();
        check("bp_a_iready", 32'(iready), 32'd1);
        check("bp_a_odata",  odata,       32'h1111_1111);
        drive(2'b01, 8'd2, 32'h2222_2222);
        step();
        check("bp_full_iready", 32'(iready), 32'd0);
        check("bp_full_odata",  odata,       32'h1111_1111);
        drive(2'b00, 8'd3, 32'h3333_3333);
        step();
        check("bp_hold_iready", 32'(iready), 32'd0);
        check("bp_hold_odata",  odata,       32'h1111_1111);
        check("bp_hold_oshift", 32'(oshift), 32'd1);
        oready = 1'b1;
        step();
        check("bp_pop1_iready", 32'(iready), 32'd1);
        check("bp_pop1_odata",  odata,       32'h2222_2222);
        check("bp_pop1_oshift", 32'(oshift), 32'd30);
        step();
        ivalid = 1'b0;
        check("bp_pop2_odata",  odata,       32'h3333_3333);
        check("bp_pop2_oshift", 32'(oshift), 32'd3);
        check("bp_pop2_ovalid", 32'(ovalid), 32'd1);
        step();
        check("bp_empty_ovalid", 32'(ovalid), 32'd0);
        check("bp_empty_odata",  odata,       32'd0);

        // Back-to-back throughput at OREADY high
        drive(2'b00, 8'd4, 32'h4444_4444);
        step();
        check("tp_d_odata", odata, 32'h4444_4444);
        drive(2'b00, 8'd6, 32'h5555_5555);
        step();
        ivalid = 1'b0;
        check("tp_e_odata",  odata,       32'h5555_5555);
        check("tp_e_oshift", 32'(oshift), 32'd6);
        check("tp_e_iready", 32'(iready), 32'd1);
        step();
        check("tp_end_ovalid", 32'(ovalid), 32'd0);

        // Reset with two entries buffered: nothing may come out afterwards
        oready = 1'b0;
        drive(2'b00, 8'd2, 32'h6666_6666);
        step();
        drive(2'b00, 8'd9, 32'h7777_7777);
        step();
        ivalid = 1'b0;
        check("mrst_full_iready", 32'(iready), 32'd0);
        check("mrst_full_ovalid", 32'(ovalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_low_iready", 32'(iready), 32'd0);
        step();
        check("mrst_ovalid", 32'(ovalid), 32'd0);
        check("mrst_odata",  odata,       32'd0);
        rst_n  = 1'b1;
        oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mrst_after_ovalid", 32'(ovalid), 32'd0);
        end
        check("mrst_after_iready", 32'(iready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
